chunker: RTL and testbench

Upstream feeder for the link stage in the discrete-event simulator. It accepts one workload token {id, size} and splits it into a sequence of chunk tokens {id, chunk_size}, each carrying at most `chunk_size_p` elements. The tokens have the same packed format the link consumes, so the link models each chunk's transfer time separately. A `last_o` sideband marks the final chunk of each workload.

---
 rtl/chunker_pkg.sv | 23 ++
 rtl/chunker.sv | 94 +++++++++
 tb/tb_chunker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chunker_pkg.sv
// Shared simulator definitions for the chunker and link stages: FSM state
// encoding and packed-token field helpers (id in the MSBs, size in the LSBs).
package chunker_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } chunker_state_e;

    localparam int token_max_width_lp = 64;

    typedef logic [token_max_width_lp-1:0] token_bits_t;

    // Helpers work on a zero-extended token; callers cast the result to their field width.
    function automatic token_bits_t token_id(input token_bits_t tok, input int size_w);
        return tok >> size_w;
    endfunction

    function automatic token_bits_t token_size(input token_bits_t tok, input int size_w);
        return tok & ((token_bits_t'(1) << size_w) - token_bits_t'(1));
    endfunction

endpackage

// File: rtl/chunker.sv
// Splits one {id, size} workload token into {id, chunk} tokens of at most
// chunk_size_p elements each; last_o marks the final chunk of a workload.

`ifndef BSG_INV_PARAM
`define BSG_INV_PARAM(param) param = 1
`endif

module chunker
    import chunker_pkg::*;
#(
    parameter int `BSG_INV_PARAM(id_width_p),
    parameter int `BSG_INV_PARAM(size_width_p),
    parameter int `BSG_INV_PARAM(chunk_size_p),
    parameter int width_p = id_width_p + size_width_p
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               last_o,
    input  logic               ready_i
);

    localparam logic [size_width_p-1:0] chunk_max_lp = size_width_p'(chunk_size_p);

    chunker_state_e            state_q, state_d;
    logic [id_width_p-1:0]     id_q, id_d;
    logic [size_width_p-1:0]   remaining_q, remaining_d;
    logic                      v_q, v_d;
    logic                      last_q, last_d;
    logic [width_p-1:0]        data_q, data_d;
    logic [size_width_p-1:0]   chunk_d;
    logic                      accept;
    logic                      xfer;

    // Finishing the last chunk frees the slot in the same cycle, so a new
    // workload can follow without a bubble.
    assign ready_o = ~reset_i & ((state_q == IDLE) | (v_q & ready_i & last_q));
    assign accept  = v_i & ready_o;
    assign xfer    = v_q & ready_i;

    assign v_o    = v_q;
    assign last_o = last_q;
    assign data_o = data_q;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        remaining_d = remaining_q;

        if (xfer) begin
            if (last_q) begin
                state_d     = IDLE;
                remaining_d = '0;
            end else begin
                remaining_d = remaining_q - chunk_max_lp;
            end
        end

        if (accept) begin
            state_d     = SEND;
            id_d        = id_width_p'(token_id(token_bits_t'(data_i), size_width_p));
            remaining_d = size_width_p'(token_size(token_bits_t'(data_i), size_width_p));
        end

        // Outputs are precomputed from the next state so they leave the flops directly.
        v_d     = (state_d == SEND);
        chunk_d = (remaining_d < chunk_max_lp) ? remaining_d : chunk_max_lp;
        last_d  = v_d & (remaining_d <= chunk_max_lp);
        data_d  = v_d ? width_p'({id_d, chunk_d}) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            id_q        <= '0;
            remaining_q <= '0;
            v_q         <= 1'b0;
            last_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            remaining_q <= remaining_d;
            v_q         <= v_d;
            last_q      <= last_d;
            data_q      <= data_d;
        end
    end

endmodule

// File: tb/tb_chunker.sv
// Scoreboard bench for chunker: workloads are split by a reference model into
// expected chunk tokens, and a monitor pops and compares each output handshake.
module tb_chunker;

    localparam int IdW    = 4;
    localparam int SizeW  = 10;
    localparam int ChunkC = 64;
    localparam int W      = IdW + SizeW;

    typedef struct {
        int id;
        int size;
        int last;
    } expTok_t;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         v_i;
    logic         v_o;
    logic [W-1:0] data_o;
    logic         last_o;
    logic         ready_i;

    expTok_t sb[$];
    int      vectors     = 0;
    int      miscompares = 0;
    int      cycle       = 0;
    bit      stopRandom  = 0;

    logic [W-1:0] heldData;
    logic         heldLast;
    bit           holdValid = 0;

    chunker #(
        .id_width_p  (IdW),
        .size_width_p(SizeW),
        .chunk_size_p(ChunkC)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .v_i    (v_i),
        .v_o    (v_o),
        .data_o (data_o),
        .last_o (last_o),
        .ready_i(ready_i)
    );

    // Free-running clock and a cycle counter used for accept-time comparisons.
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference split: ceil(size/C) chunks (at least one), full chunks first, remainder last.
    task automatic pushModel(input int id, input int size);
        int      n;
        expTok_t e;
        n = (size == 0) ? 1 : (size + ChunkC - 1) / ChunkC;
        for (int k = 0; k < n; k++) begin
            e.id   = id;
            e.size = (k < n - 1) ? ChunkC : size - ChunkC * (n - 1);
            e.last = (k == n - 1) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 one cycle after the accept edge.
    task automatic applyStimulus(input int id, input int size, output int acceptCycle);
        bit accepted = 0;
        acceptCycle = -1;
        v_i    = 1'b1;
        data_i = W'((id << SizeW) | size);
        for (int c = 0; c < 4000 && !accepted; c++) begin
            @(negedge clk_i);
            if (ready_o) begin
                pushModel(id, size);
                accepted    = 1;
                acceptCycle = cycle;
            end
        end
        if (!accepted) begin
            checkOutput("workload accepted before timeout", 0, 1);
            v_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1;
            v_i    = 1'b0;
            data_i = W'($urandom);
            @(negedge clk_i);
            checkOutput("first chunk one cycle after accept", v_o, 1);
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 20000 && sb.size() > 0; c++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("scoreboard drained", sb.size(), 0);
    endtask

    // Monitor: pops on every handshake, enforces hold under backpressure and zeros when idle.
    always @(negedge clk_i) begin
        expTok_t e;
        #1;
        if (reset_i) begin
            holdValid = 0;
        end else if (!v_o) begin
            checkOutput("idle data_o", data_o, 0);
            checkOutput("idle last_o", last_o, 0);
            if (holdValid) checkOutput("v_o held under backpressure", v_o, 1);
            holdValid = 0;
        end else begin
            if (holdValid) begin
                checkOutput("held data_o", data_o, heldData);
                checkOutput("held last_o", last_o, heldLast);
            end
            if (ready_i) begin
                holdValid = 0;
                if (sb.size() == 0) begin
                    checkOutput("expected tokens pending at handshake", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    checkOutput("chunk id", data_o[W-1:SizeW], e.id);
                    checkOutput("chunk size", data_o[SizeW-1:0], e.size);
                    checkOutput("chunk last_o", last_o, e.last);
                end
            end else begin
                heldData  = data_o;
                heldLast  = last_o;
                holdValid = 1;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc;
        int acc5;
        int acc6;

        reset_i = 1'b1;
        v_i     = 1'b1;
        ready_i = 1'b1;
        data_i  = W'($urandom);

        // Reset held three cycles with v_i asserted.
        repeat (3) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput("ready_o during reset", ready_o, 0);
            checkOutput("v_o during reset", v_o, 0);
        end
        reset_i = 1'b0;
        v_i     = 1'b0;
        @(negedge clk_i);
        checkOutput("ready_o after reset", ready_o, 1);
        checkOutput("v_o after reset", v_o, 0);
        checkOutput("data_o after reset", data_o, 0);
        checkOutput("last_o after reset", last_o, 0);
        @(posedge clk_i);
        #1;

        $display("[TB] workload {3,200}");
        applyStimulus(3, 200, acc);
        drain();

        $display("[TB] back-to-back {5,128} then {6,0}");
        applyStimulus(5, 128, acc5);
        applyStimulus(6, 0, acc6);
        checkOutput("zero-size workload accepted on last-chunk cycle", acc6 - acc5, 2);
        drain();

        $display("[TB] backpressure {1,100}");
        ready_i = 1'b0;
        applyStimulus(1, 100, acc);
        @(negedge clk_i);
        checkOutput("stalled data_o", data_o, (1 << SizeW) | 64);
        checkOutput("stalled last_o", last_o, 0);
        checkOutput("stalled ready_o", ready_o, 0);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        drain();

        $display("[TB] reset during {2,300}");
        applyStimulus(2, 300, acc);
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        sb.delete();
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        @(negedge clk_i);
        checkOutput("v_o after mid-send reset", v_o, 0);
        @(posedge clk_i);
        #1;
        applyStimulus(7, 10, acc);
        drain();

        $display("[TB] random workloads");
        fork
            begin
                while (!stopRandom) begin
                    @(posedge clk_i);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 1000; n++) begin
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 1023), acc);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
        end
        stopRandom = 1;
        @(posedge clk_i);
        #2;
        ready_i = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
